// File: rtl/rr_merge_arbiter_dataless_pkg.sv
// rr_merge_arbiter_dataless_pkg: shared sizing helper for the round-robin merge arbiter.
package rr_merge_arbiter_dataless_pkg;
   function automatic int idx_width(int size);
      return size > 1 ? $clog2(size) : 1;
   endfunction
endpackage

// File: rtl/rr_merge_arbiter_dataless_if.sv
// rr_merge_arbiter_dataless_if: input tokens, output token channel and index channel.
interface rr_merge_arbiter_dataless_if
   import rr_merge_arbiter_dataless_pkg::*;
#(
   parameter int SIZE        = 2,
   parameter int INDEX_WIDTH = idx_width(SIZE)
) ();
   logic [SIZE-1:0]        ins_valid;
   logic [SIZE-1:0]        ins_ready;
   logic                   outs_valid;
   logic                   outs_ready;
   logic [INDEX_WIDTH-1:0] index;
   logic                   index_valid;
   logic                   index_ready;
   modport master (
      input  ins_valid, outs_ready, index_ready,
      output ins_ready, outs_valid, index, index_valid
   );
   modport slave (
      output ins_valid, outs_ready, index_ready,
      input  ins_ready, outs_valid, index, index_valid
   );
endinterface

// File: rtl/rr_merge_arbiter_dataless_picker.sv
// rr_priority_picker: first set request at or after ptr, wrapping, via a double-width rotate-scan.
module rr_priority_picker
   import rr_merge_arbiter_dataless_pkg::*;
#(
   parameter int SIZE = 2,
   parameter int IW   = idx_width(SIZE)
) (
   input  logic [SIZE-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            any,
   output logic [IW-1:0]   grant_idx,
   output logic [SIZE-1:0] grant_onehot
);
   localparam logic [IW:0] SZ = (IW+1)'(SIZE);
   logic [2*SIZE-1:0] dbl;
   logic [IW:0]       off;
   logic [IW:0]       sum;
   assign dbl = {req, req} >> ptr;
   always_comb begin
      off = '0;
      for (int i = SIZE - 1; i >= 0; i--)
         if (dbl[i]) off = (IW+1)'(i);
   end
   assign any          = |req;
   assign sum          = {1'b0, ptr} + off;
   assign grant_idx    = IW'(sum >= SZ ? sum - SZ : sum);
   assign grant_onehot = any ? SIZE'(1) << grant_idx : '0;
endmodule

// File: rtl/rr_merge_arbiter_dataless.sv
// rr_merge_arbiter_dataless: round-robin merge into a one-slot register forked to token and index channels.
module rr_merge_arbiter_dataless
   import rr_merge_arbiter_dataless_pkg::*;
#(
   parameter int SIZE        = 2,
   parameter int INDEX_WIDTH = idx_width(SIZE)
) (
   input logic                      clk,
   input logic                      rst,
   rr_merge_arbiter_dataless_if.master bus
);
   localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(SIZE - 1);
   logic                   full, sent_outs, sent_index;
   logic [INDEX_WIDTH-1:0] idx_q, ptr, g;
   logic [SIZE-1:0]        onehot;
   logic                   any, done, load;
   rr_priority_picker #(.SIZE(SIZE), .IW(INDEX_WIDTH)) u_pick (
      .req          (bus.ins_valid),
      .ptr          (ptr),
      .any          (any),
      .grant_idx    (g),
      .grant_onehot (onehot)
   );
   assign done            = full & (sent_outs | bus.outs_ready) & (sent_index | bus.index_ready);
   assign load            = (~full | done) & any;
   assign bus.ins_ready   = (rst & load) ? onehot : '0;
   assign bus.outs_valid  = full & ~sent_outs;
   assign bus.index_valid = full & ~sent_index;
   assign bus.index       = idx_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         full       <= 1'b0;
         sent_outs  <= 1'b0;
         sent_index <= 1'b0;
         idx_q      <= '0;
         ptr        <= '0;
      end else if (load) begin
         full       <= 1'b1;
         sent_outs  <= 1'b0;
         sent_index <= 1'b0;
         idx_q      <= g;
         ptr        <= (g == LAST) ? '0 : g + 1'b1;
      end else if (done) begin
         full       <= 1'b0;
         sent_outs  <= 1'b0;
         sent_index <= 1'b0;
      end else begin
         sent_outs  <= sent_outs | (bus.outs_valid & bus.outs_ready);
         sent_index <= sent_index | (bus.index_valid & bus.index_ready);
      end
endmodule

// File: tb/tb_rr_merge_arbiter_dataless.sv
// tb_rr_merge_arbiter_dataless: directed checks of a SIZE=4 and a SIZE=1 arbiter.
module tb_rr_merge_arbiter_dataless;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int n_cmp = 0, n_bad = 0;
   int loads4 = 0, outs4 = 0, idx4 = 0, acc1 = 0, outs1 = 0, idx1 = 0;
   always #5 clk = ~clk;
   rr_merge_arbiter_dataless_if #(.SIZE(4)) a ();
   rr_merge_arbiter_dataless_if #(.SIZE(1)) b ();
   rr_merge_arbiter_dataless #(.SIZE(4)) u4 (.clk(clk), .rst(rst), .bus(a.master));
   rr_merge_arbiter_dataless #(.SIZE(1)) u1 (.clk(clk), .rst(rst), .bus(b.master));
   // transfer counters; a reset discards any pending token so counts restart
   always @(posedge clk or negedge rst)
      if (!rst) begin
         loads4 <= 0; outs4 <= 0; idx4 <= 0; acc1 <= 0; outs1 <= 0; idx1 <= 0;
      end else begin
         loads4 <= loads4 + int'(|(a.ins_valid & a.ins_ready));
         outs4  <= outs4 + int'(a.outs_valid & a.outs_ready);
         idx4   <= idx4 + int'(a.index_valid & a.index_ready);
         acc1   <= acc1 + int'(b.ins_valid & b.ins_ready);
         outs1  <= outs1 + int'(b.outs_valid & b.outs_ready);
         idx1   <= idx1 + int'(b.index_valid & b.index_ready);
      end
   task automatic check(input string tag, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   initial begin
      a.ins_valid = '0; a.outs_ready = 1'b0; a.index_ready = 1'b0;
      b.ins_valid = '0; b.outs_ready = 1'b0; b.index_ready = 1'b0;
      repeat (2) tick;
      a.ins_valid = 4'b1111; #1;
      check("rst_ins_ready", a.ins_ready, 0);
      check("rst_outs_valid", a.outs_valid, 0);
      check("rst_index_valid", a.index_valid, 0);
      check("rst_index", a.index, 0);
      rst = 1'b1; a.ins_valid = 4'b0110; #1;
      check("first_grant", a.ins_ready, 4'b0010);
      tick;
      check("first_index", a.index, 1);
      check("first_outs_valid", a.outs_valid, 1);
      a.ins_valid = '0; #1;
      rst = 1'b0; #1;
      check("midrst_outs_valid", a.outs_valid, 0);
      check("midrst_index_valid", a.index_valid, 0);
      a.ins_valid = 4'b1111; #1;
      check("midrst_ins_ready", a.ins_ready, 0);
      tick;
      rst = 1'b1; #1;
      check("postrst_grant", a.ins_ready, 4'b0001);
      a.outs_ready = 1'b1; a.index_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick;
         check("seq_index", a.index, k % 4);
         check("seq_valids", {a.outs_valid, a.index_valid}, 3);
         check("seq_ready", a.ins_ready, 1 << ((k + 1) % 4));
      end
      a.ins_valid = 4'b1010; #1;
      check("sparse_ready0", a.ins_ready, 4'b0010);
      tick;
      check("sparse_index0", a.index, 1);
      check("sparse_ready1", a.ins_ready, 4'b1000);
      tick;
      check("sparse_index1", a.index, 3);
      check("sparse_wrap", a.ins_ready, 4'b0010);
      tick;
      check("sparse_index2", a.index, 1);
      a.ins_valid = 4'b1111; a.index_ready = 1'b0; #1;
      check("split_block", a.ins_ready, 0);
      for (int k = 0; k < 3; k++) begin
         tick;
         check("split_outs_valid", a.outs_valid, 0);
         check("split_index_valid", a.index_valid, 1);
         check("split_index", a.index, 1);
         check("split_ins_ready", a.ins_ready, 0);
      end
      a.index_ready = 1'b1; #1;
      check("split_release", a.ins_ready, 4'b0100);
      tick;
      check("split_reload_index", a.index, 2);
      check("split_reload_valids", {a.outs_valid, a.index_valid}, 3);
      a.outs_ready = 1'b0; a.index_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick;
         check("stall_ins_ready", a.ins_ready, 0);
         check("stall_index", a.index, 2);
         check("stall_valids", {a.outs_valid, a.index_valid}, 3);
      end
      a.index_ready = 1'b1;
      tick;
      check("order_valids", {a.outs_valid, a.index_valid}, 2);
      check("order_ins_ready", a.ins_ready, 0);
      a.index_ready = 1'b0; a.outs_ready = 1'b1; a.ins_valid = '0;
      tick;
      check("drain_valids", {a.outs_valid, a.index_valid}, 0);
      a.outs_ready = 1'b0; a.ins_valid = 4'b0001; #1;
      check("drain_wrap_grant", a.ins_ready, 4'b0001);
      check("count_loads", loads4, 12);
      check("count_outs", outs4, 12);
      check("count_index", idx4, 12);
      a.ins_valid = '0;
      b.ins_valid = 1'b1; #1;
      check("s1_ready_empty", b.ins_ready, 1);
      tick;
      check("s1_ready_full", b.ins_ready, 0);
      check("s1_outs_valid", b.outs_valid, 1);
      check("s1_index", b.index, 0);
      for (int k = 0; k < 40; k++) begin
         b.ins_valid   = (k % 3) != 0;
         b.outs_ready  = 1'($urandom_range(0, 1));
         b.index_ready = 1'($urandom_range(0, 1));
         tick;
         check("s1_index_loop", b.index, 0);
      end
      b.ins_valid = 1'b0; b.outs_ready = 1'b1; b.index_ready = 1'b1;
      repeat (3) tick;
      check("s1_drained", b.outs_valid, 0);
      check("s1_some_accepted", int'(acc1 > 1), 1);
      check("s1_outs_count", outs1, acc1);
      check("s1_index_count", idx1, acc1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
